clk_phase_scheduler: RTL and testbench

//  Programmable quadrature clock-enable scheduler on clock48. Produces clk_a/clk_b (90-deg apart)
//  and four one-cycle phase strobes per period. Period length (div) is set via a cfg handshake and

---
 rtl/clk_sched_pkg.sv | 18 +
 rtl/clk_sched_cfg.sv | 71 +++++++
 rtl/clk_phase_scheduler.sv | 146 ++++++++++++++
 tb/tb_clk_phase_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the clock48 quadrature phase scheduler.
package clk_sched_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_MIN   = 4;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_e;

    // A period must split into four equal quarters and hold at least one cycle per quarter.
    function automatic logic div_is_legal(input logic [31:0] div);
        return (div[1:0] == 2'b00) && (div >= 32'(DIV_MIN));
    endfunction

endpackage

// File: rtl/clk_sched_cfg.sv
// Period-length configuration: handshake, legality check, deferred update and error pulse.
module clk_sched_cfg
    import clk_sched_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             defer_i,
    input  logic             apply_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic [CNT_W-1:0] div_act_o
);

    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic             err_q, err_d;
    logic             accept_s;
    logic             legal_s;

    assign accept_s = cfg_valid_i & ~pend_vld_q;
    assign legal_s  = div_is_legal(32'(cfg_div_i));

    // Next-state for the active/pending period length and the error pulse.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_div_d = pend_div_q;
        div_act_d  = div_act_q;
        err_d      = 1'b0;
        if (apply_i && pend_vld_q) begin
            div_act_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end else if (accept_s) begin
            if (!legal_s) begin
                err_d = 1'b1;
            end else if (defer_i) begin
                pend_div_d = cfg_div_i;
                pend_vld_d = 1'b1;
            end else begin
                div_act_d = cfg_div_i;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // Configuration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_vld_q <= 1'b0;
            pend_div_q <= {CNT_W{1'b0}};
            div_act_q  <= CNT_W'(DIV_DEFAULT);
            err_q      <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_div_q <= pend_div_d;
            div_act_q  <= div_act_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready_o = ~pend_vld_q;
    assign cfg_err_o   = err_q;
    assign div_act_o   = div_act_q;

endmodule

// File: rtl/clk_phase_scheduler.sv
// Quadrature clock-enable scheduler on clock48 with programmable period length.
// Optional completed-period counter port enabled by CLKSCHED_PERIOD_CNT_EN.
module clk_phase_scheduler
    import clk_sched_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clock48,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_a,
    output logic             clk_b,
    output logic [3:0]       ph_strobe,
    output logic             period_start
`ifdef CLKSCHED_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    sched_state_e     state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] div_act_s;
    logic [CNT_W-1:0] half_s, q_s, q2_s, q3_s;
    logic             wrap_s, defer_s, apply_s;
    logic             clk_a_d, clk_b_d;
    logic [3:0]       ph_d;
    logic             clk_a_q, clk_b_q;
    logic [3:0]       ph_q;

    // While running, a new length waits for a wrap; leaving RUN flushes it immediately.
    assign defer_s = (state_q == ST_RUN) && run;
    assign apply_s = (state_q == ST_RUN) && (wrap_s || !run);

    clk_sched_cfg #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_cfg (
        .clk_i       (clock48),
        .rst_i       (reset),
        .cfg_valid_i (cfg_valid),
        .cfg_div_i   (cfg_div),
        .defer_i     (defer_s),
        .apply_i     (apply_s),
        .cfg_ready_o (cfg_ready),
        .cfg_err_o   (cfg_err),
        .div_act_o   (div_act_s)
    );

    // q never exceeds a quarter of the counter range, so 3q cannot overflow.
    assign half_s = div_act_s >> 1;
    assign q_s    = div_act_s >> 2;
    assign q2_s   = q_s << 1;
    assign q3_s   = q_s + q2_s;
    assign wrap_s = (count_q == (div_act_s - CNT_W'(1)));

    // Output decode from the current count.
    always_comb begin
        clk_a_d = (count_q < half_s);
        clk_b_d = (count_q >= q_s) && (count_q < q3_s);
        ph_d[0] = (count_q == {CNT_W{1'b0}});
        ph_d[1] = (count_q == q_s);
        ph_d[2] = (count_q == q2_s);
        ph_d[3] = (count_q == q3_s);
    end

    // Run-control FSM with period counter and registered outputs.
    always_ff @(posedge clock48) begin
        if (reset) begin
            state_q <= ST_STOP;
            count_q <= {CNT_W{1'b0}};
            clk_a_q <= 1'b0;
            clk_b_q <= 1'b0;
            ph_q    <= 4'b0000;
        end else begin
            case (state_q)
                ST_STOP: begin
                    state_q <= run ? ST_ARM : ST_STOP;
                    count_q <= {CNT_W{1'b0}};
                    clk_a_q <= 1'b0;
                    clk_b_q <= 1'b0;
                    ph_q    <= 4'b0000;
                end
                ST_ARM: begin
                    state_q <= run ? ST_RUN : ST_STOP;
                    count_q <= {CNT_W{1'b0}};
                    clk_a_q <= 1'b0;
                    clk_b_q <= 1'b0;
                    ph_q    <= 4'b0000;
                end
                ST_RUN: begin
                    if (run) begin
                        state_q <= ST_RUN;
                        count_q <= wrap_s ? {CNT_W{1'b0}} : (count_q + CNT_W'(1));
                        clk_a_q <= clk_a_d;
                        clk_b_q <= clk_b_d;
                        ph_q    <= ph_d;
                    end else begin
                        state_q <= ST_STOP;
                        count_q <= {CNT_W{1'b0}};
                        clk_a_q <= 1'b0;
                        clk_b_q <= 1'b0;
                        ph_q    <= 4'b0000;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                    count_q <= {CNT_W{1'b0}};
                    clk_a_q <= 1'b0;
                    clk_b_q <= 1'b0;
                    ph_q    <= 4'b0000;
                end
            endcase
        end
    end

    assign clk_a        = clk_a_q;
    assign clk_b        = clk_b_q;
    assign ph_strobe    = ph_q;
    assign period_start = ph_q[0];

`ifdef CLKSCHED_PERIOD_CNT_EN
    logic [15:0] pcnt_q;

    // Completed-period counter, only alive while RUN continues.
    always_ff @(posedge clock48) begin
        if (reset) begin
            pcnt_q <= 16'd0;
        end else if ((state_q == ST_RUN) && run && wrap_s) begin
            pcnt_q <= pcnt_q + 16'd1;
        end else if ((state_q != ST_RUN) || !run) begin
            pcnt_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_q;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_phase_scheduler.sv
// Directed self-checking bench for clk_phase_scheduler (period counter checks under CLKSCHED_PERIOD_CNT_EN).
module tb_clk_phase_scheduler;

    logic       clock48 = 1'b0;
    logic       reset;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_a;
    logic       clk_b;
    logic [3:0] ph_strobe;
    logic       period_start;
`ifdef CLKSCHED_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Expected per-count outputs for div=4 and div=8.
    logic       a4  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       b4  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ph4 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic       a8  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       b8  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] ph8 [8] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};

    always #5 clock48 = ~clock48;

    clk_phase_scheduler #(
        .CNT_W       (8),
        .DIV_DEFAULT (4)
    ) dut (
        .clock48      (clock48),
        .reset        (reset),
        .run          (run),
        .cfg_valid    (cfg_valid),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .clk_a        (clk_a),
        .clk_b        (clk_b),
        .ph_strobe    (ph_strobe),
        .period_start (period_start)
`ifdef CLKSCHED_PERIOD_CNT_EN
        ,
        .period_cnt   (period_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock48);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic a, input logic b, input logic [3:0] ph);
        chk($sformatf("%s clk_a", tag), 16'(clk_a), 16'(a));
        chk($sformatf("%s clk_b", tag), 16'(clk_b), 16'(b));
        chk($sformatf("%s ph_strobe", tag), 16'(ph_strobe), 16'(ph));
        chk($sformatf("%s period_start", tag), 16'(period_start), 16'(ph[0]));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        tick(); tick();
        expect_out("reset", 1'b0, 1'b0, 4'h0);
        chk("reset cfg_ready", 16'(cfg_ready), 16'd1);
        chk("reset cfg_err", 16'(cfg_err), 16'd0);
        reset = 1'b0;

        // Start-up latency and div=4 pattern
        run = 1'b1;
        tick(); expect_out("arm", 1'b0, 1'b0, 4'h0);
        tick(); expect_out("run entry", 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_out($sformatf("div4 c%0d", i % 4), a4[i % 4], b4[i % 4], ph4[i % 4]);
        end

        // Illegal lengths 6 and 0
        cfg_valid = 1'b1; cfg_div = 8'd6;
        tick();
        chk("err6 pulse", 16'(cfg_err), 16'd1);
        chk("err6 ready", 16'(cfg_ready), 16'd1);
        expect_out("err6 c0", a4[0], b4[0], ph4[0]);
        cfg_div = 8'd0;
        tick();
        chk("err0 pulse", 16'(cfg_err), 16'd1);
        chk("err0 ready", 16'(cfg_ready), 16'd1);
        expect_out("err0 c1", a4[1], b4[1], ph4[1]);
        cfg_valid = 1'b0;
        tick();
        chk("err clear", 16'(cfg_err), 16'd0);
        expect_out("after err c2", a4[2], b4[2], ph4[2]);
        tick(); expect_out("after err c3", a4[3], b4[3], ph4[3]);
        tick(); expect_out("after err c0", a4[0], b4[0], ph4[0]);

        // Mid-period change to 8
        cfg_valid = 1'b1; cfg_div = 8'd8;
        tick();
        chk("div8 pending ready", 16'(cfg_ready), 16'd0);
        expect_out("div8 pend c1", a4[1], b4[1], ph4[1]);
        cfg_valid = 1'b0;
        tick(); chk("div8 still pending", 16'(cfg_ready), 16'd0);
        tick();
        chk("div8 applied ready", 16'(cfg_ready), 16'd1);
        expect_out("div8 last old c3", a4[3], b4[3], ph4[3]);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_out($sformatf("div8 c%0d", i), a8[i], b8[i], ph8[i]);
        end

        // Request accepted on the wrap edge applies one period later
        for (int i = 0; i < 7; i++) begin
            tick(); expect_out($sformatf("div8b c%0d", i), a8[i], b8[i], ph8[i]);
        end
        cfg_valid = 1'b1; cfg_div = 8'd4;
        tick();
        chk("wrap accept ready", 16'(cfg_ready), 16'd0);
        expect_out("div8b c7", a8[7], b8[7], ph8[7]);
        cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); expect_out($sformatf("div8c c%0d", i), a8[i], b8[i], ph8[i]);
        end
        chk("wrap accept applied", 16'(cfg_ready), 16'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out($sformatf("back4 c%0d", i), a4[i], b4[i], ph4[i]);
        end

        // Stop at count 2, then restart
        tick(); expect_out("pre-stop c0", a4[0], b4[0], ph4[0]);
        tick(); expect_out("pre-stop c1", a4[1], b4[1], ph4[1]);
        run = 1'b0;
        tick(); expect_out("stop", 1'b0, 1'b0, 4'h0);
        run = 1'b1;
        tick(); expect_out("restart arm", 1'b0, 1'b0, 4'h0);
        tick(); expect_out("restart run", 1'b0, 1'b0, 4'h0);
        tick(); expect_out("restart c0", a4[0], b4[0], ph4[0]);
        tick(); expect_out("restart c1", a4[1], b4[1], ph4[1]);

        // Reset with a pending div=12
        cfg_valid = 1'b1; cfg_div = 8'd12;
        tick(); chk("div12 pending", 16'(cfg_ready), 16'd0);
        cfg_valid = 1'b0; reset = 1'b1;
        tick();
        expect_out("mid reset", 1'b0, 1'b0, 4'h0);
        chk("mid reset ready", 16'(cfg_ready), 16'd1);
        chk("mid reset err", 16'(cfg_err), 16'd0);
        reset = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick(); expect_out($sformatf("post reset c%0d", i % 4), a4[i % 4], b4[i % 4], ph4[i % 4]);
        end

        // Pending div=8 flushed when run falls
        cfg_valid = 1'b1; cfg_div = 8'd8;
        tick(); chk("fall pending", 16'(cfg_ready), 16'd0);
        cfg_valid = 1'b0; run = 1'b0;
        tick();
        chk("fall applied ready", 16'(cfg_ready), 16'd1);
        expect_out("fall stop", 1'b0, 1'b0, 4'h0);
        run = 1'b1;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tick(); expect_out($sformatf("fall div8 c%0d", i), a8[i], b8[i], ph8[i]);
        end
        run = 1'b0;
        tick(); expect_out("stop2", 1'b0, 1'b0, 4'h0);
`ifdef CLKSCHED_PERIOD_CNT_EN
        chk("period_cnt stop2", period_cnt, 16'd0);
`endif

        // Immediate update in STOP, then ten div=4 periods
        cfg_valid = 1'b1; cfg_div = 8'd4;
        tick(); chk("stop cfg ready", 16'(cfg_ready), 16'd1);
        cfg_valid = 1'b0; run = 1'b1;
        tick(); tick();
        for (int i = 0; i < 40; i++) begin
            tick(); expect_out($sformatf("ten c%0d", i % 4), a4[i % 4], b4[i % 4], ph4[i % 4]);
        end
`ifdef CLKSCHED_PERIOD_CNT_EN
        chk("period_cnt ten", period_cnt, 16'd10);
`endif
        run = 1'b0;
        tick(); expect_out("final stop", 1'b0, 1'b0, 4'h0);
`ifdef CLKSCHED_PERIOD_CNT_EN
        chk("period_cnt cleared", period_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
